// File: rtl/seg_display_scan_pkg.sv
// Shared types and helpers for the 8-digit 7-segment scanner.
//   disp_src_e  : which 32-bit value is on the display
//   NUM_DIGITS  : digits on the board
//   hex_to_seg  : nibble -> active-low {g,f,e,d,c,b,a}
package seg_pkg;

  typedef enum logic [1:0] {
    SRC_LED    = 2'd0,
    SRC_ALL    = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_JMP    = 2'd3
  } disp_src_e;

  localparam int NUM_DIGITS = 8;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Bundle between the CPU-side sources / board button and the display scanner.
//   led_data, count_all, count_branch, count_jmp : 32-bit display sources
//   sel_btn  : raw source-select button (active-high, asynchronous)
//   an, seg  : active-low digit enables / segments {dp,g..a}
//   src_sel  : currently selected source
// master drives the sources and button; slave is the scanner.
interface seg_display_scan_if;
  logic [31:0] led_data;
  logic [31:0] count_all;
  logic [31:0] count_branch;
  logic [31:0] count_jmp;
  logic        sel_btn;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [1:0]  src_sel;

  modport master (
    output led_data, count_all, count_branch, count_jmp, sel_btn,
    input  an, seg, src_sel
  );

  modport slave (
    input  led_data, count_all, count_branch, count_jmp, sel_btn,
    output an, seg, src_sel
  );
endinterface

// File: rtl/seg_display_scan_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce counter, press pulse.
//   clk, clr_n : clock, async active-low reset
//   btn        : raw asynchronous button level
//   press      : one-cycle pulse when the debounced level goes 0->1
// A level change is accepted after it has persisted for DEBOUNCE_CYC
// consecutive cycles; any bounce back to the stable level restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // This is the DEBOUNCE_CYC-th differing cycle: accept the level.
        stable <= s2;
        cnt    <= '0;
        press  <= s2;  // release (1->0) gives no pulse
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_display_scan.sv
// 8-digit common-anode multiplexed 7-segment driver for the CPU outputs.
//   clk, clr_n : clock, async active-low reset
//   bus        : seg_display_scan_if.slave (sources, button, an/seg/src_sel)
// The button cycles LED -> ALL -> BRANCH -> JMP. The selected source is
// snapshotted once per frame (when the digit index wraps to 0) so a frame
// never mixes two values. dp marks the selected source on digits 0-3.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the
// most-significant non-zero nibble (digit 0 is always shown).
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic                clk,
  input  logic                clr_n,
  seg_display_scan_if.slave   bus
);
  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div;
  logic [2:0]    idx, idx_nxt;
  logic          tick, wrap, press;
  disp_src_e     src;
  logic [31:0]   snap, snap_nxt, src_val;
  logic [7:0]    an_q, seg_q;
  logic [7:0]    blank_nxt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (bus.sel_btn),
    .press (press)
  );

  assign tick    = (div == DW'(SCAN_DIV - 1));
  assign idx_nxt = idx + 3'd1;
  assign wrap    = tick && (idx == 3'd7);

  always_comb begin
    src_val = bus.led_data;
    case (src)
      SRC_ALL:    src_val = bus.count_all;
      SRC_BRANCH: src_val = bus.count_branch;
      SRC_JMP:    src_val = bus.count_jmp;
      default:    src_val = bus.led_data;
    endcase
  end

  // The digit shown right after a wrap must come from the new snapshot,
  // so the output registers look at the value being loaded.
  assign snap_nxt = wrap ? src_val : snap;

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] blank, load_mask;
  logic       zero_above;

  // Mask is fixed per frame: built from the incoming snapshot at load.
  always_comb begin
    load_mask  = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above   = zero_above && (src_val[4*i +: 4] == 4'h0);
      load_mask[i] = zero_above;
    end
  end

  assign blank_nxt = wrap ? load_mask : blank;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    blank <= '0;
    else if (wrap) blank <= load_mask;
  end
`else
  assign blank_nxt = '0;
`endif

  // Source FSM
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      src <= SRC_LED;
    end else if (press) begin
      case (src)
        SRC_LED:    src <= SRC_ALL;
        SRC_ALL:    src <= SRC_BRANCH;
        SRC_BRANCH: src <= SRC_JMP;
        default:    src <= SRC_LED;
      endcase
    end
  end

  // Divider, digit index, snapshot and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div   <= '0;
      idx   <= '0;
      snap  <= '0;
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx        <= idx_nxt;
        snap       <= snap_nxt;
        an_q       <= ~(8'b1 << idx_nxt);
        seg_q[7]   <= (idx_nxt != {1'b0, src});
        seg_q[6:0] <= blank_nxt[idx_nxt] ? 7'h7F
                                         : hex_to_seg(snap_nxt[{idx_nxt, 2'b00} +: 4]);
      end
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.src_sel = src;
endmodule
